// File: rtl/branch_pkg.sv
// Shared constants and saturating-counter helpers for the branch unit and its BTB.
package branch_pkg;

    localparam logic ADDR_PC   = 1'b0;
    localparam logic ADDR_RD   = 1'b1;
    localparam int   PC_STEP   = 4;
    localparam int   CTR_MAX_W = 8;

    typedef logic [CTR_MAX_W-1:0] ctr_t;

    // w is the live counter width; callers truncate the result back to w bits
    function automatic ctr_t sat_inc(input ctr_t c, input int unsigned w);
        ctr_t top;
        top = ctr_t'((1 << w) - 1);
        return (c >= top) ? top : c + ctr_t'(1);
    endfunction

    function automatic ctr_t sat_dec(input ctr_t c);
        return (c == '0) ? '0 : c - ctr_t'(1);
    endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped branch target buffer: registered lookup port, single update port.
module btb_table import branch_pkg::*; #(
    parameter int WORD_SIZE = 32,
    parameter int BTB_DEPTH = 16,
    parameter int CTR_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 f_valid,
    input  logic [WORD_SIZE-1:0] f_pc,
    output logic                 p_valid,
    output logic [WORD_SIZE-1:0] p_pc,
    output logic                 p_taken,
    output logic [WORD_SIZE-1:0] p_target,
    input  logic                 upd_en,
    input  logic [WORD_SIZE-1:2] upd_pc,
    input  logic                 upd_taken,
    input  logic [WORD_SIZE-1:0] upd_target
);
    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = WORD_SIZE - IDX_W - 2;
    localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'(1) << (CTR_WIDTH - 1);

    logic [BTB_DEPTH-1:0] vld_q;
    logic [TAG_W-1:0]     tag_q [BTB_DEPTH];
    logic [WORD_SIZE-1:0] tgt_q [BTB_DEPTH];
    logic [CTR_WIDTH-1:0] ctr_q [BTB_DEPTH];

    logic [IDX_W-1:0]     lk_idx, up_idx;
    logic [TAG_W-1:0]     lk_tag, up_tag;
    logic                 lk_taken, up_hit;
    logic [CTR_WIDTH-1:0] ctr_inc, ctr_dec;

    always_comb begin
        lk_idx   = f_pc[IDX_W+1:2];
        lk_tag   = f_pc[WORD_SIZE-1:IDX_W+2];
        lk_taken = vld_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && ctr_q[lk_idx][CTR_WIDTH-1];
        up_idx   = upd_pc[IDX_W+1:2];
        up_tag   = upd_pc[WORD_SIZE-1:IDX_W+2];
        up_hit   = vld_q[up_idx] && (tag_q[up_idx] == up_tag);
        ctr_inc  = CTR_WIDTH'(sat_inc(ctr_t'(ctr_q[up_idx]), CTR_WIDTH));
        ctr_dec  = CTR_WIDTH'(sat_dec(ctr_t'(ctr_q[up_idx])));
    end

    // Lookup samples pre-update storage, so a same-edge update is not visible
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p_valid  <= 1'b0;
            p_pc     <= '0;
            p_taken  <= 1'b0;
            p_target <= '0;
        end else if (f_valid) begin
            p_valid  <= 1'b1;
            p_pc     <= f_pc;
            p_taken  <= lk_taken;
            p_target <= lk_taken ? tgt_q[lk_idx] : f_pc + WORD_SIZE'(PC_STEP);
        end else begin
            p_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q <= '0;
            for (int i = 0; i < BTB_DEPTH; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= '0;
            end
        end else if (upd_en) begin
            if (upd_taken) begin
                tgt_q[up_idx] <= upd_target;
                if (up_hit) begin
                    ctr_q[up_idx] <= ctr_inc;
                end else begin
                    vld_q[up_idx] <= 1'b1;
                    tag_q[up_idx] <= up_tag;
                    ctr_q[up_idx] <= CTR_INIT;
                end
            end else if (up_hit) begin
                ctr_q[up_idx] <= ctr_dec;
            end
        end
    end

endmodule

// File: rtl/branch_unit_btb.sv
// Execute-stage target resolve, mispredict redirect handshake and BTB training.
module branch_unit_btb import branch_pkg::*; #(
    parameter int WORD_SIZE = 32,
    parameter int BTB_DEPTH = 16,
    parameter int CTR_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 f_valid,
    input  logic [WORD_SIZE-1:0] f_pc,
    output logic                 p_valid,
    output logic [WORD_SIZE-1:0] p_pc,
    output logic                 p_taken,
    output logic [WORD_SIZE-1:0] p_target,
    input  logic                 e_valid,
    output logic                 e_ready,
    input  logic                 e_addr_mode,
    input  logic                 e_taken,
    input  logic [WORD_SIZE-1:0] e_imm,
    input  logic [WORD_SIZE-1:0] e_rs1d,
    input  logic [WORD_SIZE-1:0] e_pc,
    input  logic                 e_pred_taken,
    input  logic [WORD_SIZE-1:0] e_pred_target,
    output logic [WORD_SIZE-1:0] branch_addr,
    output logic [WORD_SIZE-1:0] npc,
    output logic                 redirect_valid,
    output logic [WORD_SIZE-1:0] redirect_pc,
    input  logic                 redirect_ready
);
    logic [WORD_SIZE-1:0] rd_sum, target, seq, actual;
    logic                 mispredict, accept;

    always_comb begin
        rd_sum     = e_rs1d + e_imm;
        target     = (e_addr_mode == ADDR_RD) ? {rd_sum[WORD_SIZE-1:1], 1'b0} : e_pc + e_imm;
        seq        = e_pc + WORD_SIZE'(PC_STEP);
        actual     = e_taken ? target : seq;
        mispredict = (e_pred_taken != e_taken) || (e_taken && (e_pred_target != target));
        e_ready    = !redirect_valid || redirect_ready;
        accept     = e_valid && e_ready;
    end

    // A new mispredict on the handoff edge replaces the redirect instead of clearing it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            branch_addr    <= '0;
            npc            <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            if (accept) begin
                branch_addr <= target;
                npc         <= actual;
            end
            if (accept && mispredict) begin
                redirect_valid <= 1'b1;
                redirect_pc    <= actual;
            end else if (redirect_ready) begin
                redirect_valid <= 1'b0;
            end
        end
    end

    btb_table #(
        .WORD_SIZE(WORD_SIZE),
        .BTB_DEPTH(BTB_DEPTH),
        .CTR_WIDTH(CTR_WIDTH)
    ) u_btb (
        .clk       (clk),
        .rstn      (rstn),
        .f_valid   (f_valid),
        .f_pc      (f_pc),
        .p_valid   (p_valid),
        .p_pc      (p_pc),
        .p_taken   (p_taken),
        .p_target  (p_target),
        .upd_en    (accept),
        .upd_pc    (e_pc[WORD_SIZE-1:2]),
        .upd_taken (e_taken),
        .upd_target(target)
    );

endmodule
